// File: rtl/md_unit_if.sv
// md_unit_if -- issue/result bundle between the EX stage and the multiply/divide unit.
//   start  : issue an operation this cycle
//   op     : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b   : rs / rt operands (already forwarded)
//   busy   : an operation is in flight
//   done   : one-cycle pulse in the cycle after HI/LO commit
//   hi, lo : architectural HI/LO registers
// The master modport is the issuing side (pipeline); slave is the md_unit itself.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers.
// The arithmetic result is computed combinationally at issue and parked in
// pending registers; a down-counter models the configured latency, after
// which the pending value is committed to HI/LO and done pulses once.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high; aborts any in-flight operation
//   bus    : md_unit_if slave modport (start/op/a/b in, busy/done/hi/lo out)
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // The counter only ever holds N-1.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic               r_pend_wr;

    // ---------------- multiply ----------------
    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;

    assign w_mul_signed = (bus.op == OP_MULT);
    // Extending to 2*WIDTH first makes the low 2*WIDTH bits of an unsigned
    // multiply equal to the two's-complement product when sign-extended.
    assign w_ext_a = w_mul_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    assign w_ext_b = w_mul_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    assign w_prod  = w_ext_a * w_ext_b;

    // ---------------- divide ----------------
    // Signed division is done on magnitudes and the signs fixed afterwards.
    // This handles MIN_INT / -1 without a special case: |MIN_INT| is
    // representable as an unsigned value, and negating it wraps back to MIN_INT.
    logic               w_div_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_num;
    logic [WIDTH-1:0]   w_den;
    logic [WIDTH-1:0]   w_den_safe;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_div_signed = (bus.op == OP_DIV);
    assign w_a_neg      = w_div_signed & bus.a[WIDTH-1];
    assign w_b_neg      = w_div_signed & bus.b[WIDTH-1];
    assign w_b_zero     = (bus.b == '0);
    assign w_num        = w_a_neg ? (-bus.a) : bus.a;
    assign w_den        = w_b_neg ? (-bus.b) : bus.b;
    // Divide-by-zero results are discarded; feed a harmless divisor instead.
    assign w_den_safe   = w_b_zero ? WIDTH'(1) : w_den;
    assign w_q_mag      = w_num / w_den_safe;
    assign w_r_mag      = w_num % w_den_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (-w_r_mag) : w_r_mag;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                r_pend_hi <= w_prod[2*WIDTH-1:WIDTH];
                                r_pend_lo <= w_prod[WIDTH-1:0];
                                r_pend_wr <= 1'b1;
                                r_cnt     <= CNT_W'(MULT_CYCLES - 1);
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_pend_hi <= w_rem;
                                r_pend_lo <= w_quot;
                                // Zero divisor still runs the full latency but leaves HI/LO alone.
                                r_pend_wr <= ~w_b_zero;
                                r_cnt     <= CNT_W'(DIV_CYCLES - 1);
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
`ifndef SYNTHESIS
                    if (bus.start) begin
                        $display("md_unit warning: start (op=%b) ignored while busy", bus.op);
                    end
`endif
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed, table-driven bench for md_unit (WIDTH=32,
// MULT_CYCLES=5, DIV_CYCLES=10). Each table row presets HI/LO with MTHI/MTLO,
// issues one operation, checks busy length, HI/LO hold, the commit values
// and the single done pulse. Hand-written sequences cover ignored starts,
// back-to-back issue, illegal op codes and reset during an operation.
module tb_md_unit;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    md_unit_if #(.WIDTH(32)) bus ();

    md_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] val);
        issue(op, val, 32'h0);
        if (op == OP_MTHI) chk($sformatf("mthi %h", val), {32'h0, bus.hi}, {32'h0, val});
        else               chk($sformatf("mtlo %h", val), {32'h0, bus.lo}, {32'h0, val});
        chk("mt no busy/done", {62'h0, bus.busy, bus.done}, 64'h0);
    endtask

    // Waits (bounded) for done; returns the number of edges waited.
    task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   n;
        int   busy_bad;
        int   hold_bad;
        v = vecs[idx];
        n = (v.op == OP_MULT || v.op == OP_MULTU) ? 5 : 10;
        busy_bad = 0;
        hold_bad = 0;
        mt(OP_MTHI, v.pre_hi);
        mt(OP_MTLO, v.pre_lo);
        issue(v.op, v.a, v.b);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
            if (bus.hi !== v.pre_hi || bus.lo !== v.pre_lo) hold_bad++;
        end
        chk($sformatf("vec%0d busy window", idx), 64'(busy_bad), 64'h0);
        chk($sformatf("vec%0d hold", idx), 64'(hold_bad), 64'h0);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d busy/done at commit", idx), {62'h0, bus.busy, bus.done}, 64'h1);
        chk($sformatf("vec%0d hi:lo", idx), {bus.hi, bus.lo}, {v.exp_hi, v.exp_lo});
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d done single", idx), {63'h0, bus.done}, 64'h0);
        $display("vec%0d op=%b a=%h b=%h -> hi=%h lo=%h", idx, v.op, v.a, v.b, bus.hi, bus.lo);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  done_cnt;

        //           op        a             b             pre_hi        pre_lo        exp_hi        exp_lo
        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000003};
        vecs[4] = '{OP_DIV,   32'h00000009, 32'h00000000, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022};
        vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h80000000};
        vecs[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'hCAFEBABE, 32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF};
        vecs[9] = '{OP_MULTU, 32'h12345678, 32'h00001000, 32'h00000000, 32'h00000000, 32'h00000123, 32'h45678000};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy/done", {62'h0, bus.busy, bus.done}, 64'h0);
        chk("reset hi:lo", {bus.hi, bus.lo}, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // MTLO issued during busy must be ignored.
        mt(OP_MTHI, 32'h0);
        mt(OP_MTLO, 32'h0);
        issue(OP_MULT, 32'h00000003, 32'h00000004);
        issue(OP_MTLO, 32'h000000AA, 32'h0);
        chk("mt-in-busy lo held", {32'h0, bus.lo}, 64'h0);
        wait_done(20, cyc, seen);
        chk("mt-in-busy done seen", {63'h0, seen}, 64'h1);
        chk("mt-in-busy latency", 64'(cyc), 64'd4);
        chk("mt-in-busy hi:lo", {bus.hi, bus.lo}, {32'h0, 32'h0000000C});
        $display("mt-in-busy: hi=%h lo=%h after %0d more edges", bus.hi, bus.lo, cyc);

        // Back-to-back: new op accepted in the done cycle.
        issue(OP_MULT, 32'h00000006, 32'h00000007);
        wait_done(20, cyc, seen);
        chk("b2b first done", {63'h0, seen}, 64'h1);
        chk("b2b first lo", {32'h0, bus.lo}, 64'd42);
        issue(OP_MULTU, 32'h00000010, 32'h00000010);
        chk("b2b second accepted", {62'h0, bus.busy, bus.done}, 64'h2);
        chk("b2b hold first result", {bus.hi, bus.lo}, {32'h0, 32'd42});
        wait_done(20, cyc, seen);
        chk("b2b second done", {63'h0, seen}, 64'h1);
        chk("b2b second latency", 64'(cyc), 64'd5);
        chk("b2b second hi:lo", {bus.hi, bus.lo}, {32'h0, 32'h00000100});
        $display("b2b: hi=%h lo=%h", bus.hi, bus.lo);

        // Illegal op code 110 is ignored.
        mt(OP_MTHI, 32'h00000055);
        mt(OP_MTLO, 32'h00000066);
        issue(3'b110, 32'h00000001, 32'h00000001);
        chk("op110 no busy/done", {62'h0, bus.busy, bus.done}, 64'h0);
        @(posedge clk);
        #1;
        chk("op110 still idle", {62'h0, bus.busy, bus.done}, 64'h0);
        chk("op110 hi:lo", {bus.hi, bus.lo}, {32'h00000055, 32'h00000066});
        $display("op110: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

        // Reset during DIVU aborts the op; no commit, no done afterwards.
        issue(OP_DIVU, 32'd100, 32'd7);
        chk("rst-run busy", {63'h0, bus.busy}, 64'h1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst-run busy/done", {62'h0, bus.busy, bus.done}, 64'h0);
        chk("rst-run hi:lo", {bus.hi, bus.lo}, 64'h0);
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_cnt++;
        end
        chk("rst-run no done", 64'(done_cnt), 64'h0);
        chk("rst-run hi:lo stays", {bus.hi, bus.lo}, 64'h0);
        $display("rst-run: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
